// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected accumulate/activate datapath.
package fc_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam int INT8_MAX = 127;

endpackage

// File: rtl/relu_q8.sv
// ReLU, arithmetic right shift and saturation of a signed accumulator to an 8-bit activation.
module relu_q8
  import fc_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int SHIFT = 4
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [7:0]       value,
  output logic                    sat
);

  localparam logic signed [ACC_W-1:0] R_MAX = ACC_W'(INT8_MAX);

  logic signed [ACC_W-1:0] pos;
  logic signed [ACC_W-1:0] r;

  // Negative sums clamp to zero before shifting, so r is never negative.
  always_comb begin
    pos   = acc[ACC_W-1] ? '0 : acc;
    r     = pos >>> SHIFT;
    sat   = (r > R_MAX);
    value = sat ? 8'(INT8_MAX) : r[7:0];
  end

endmodule

// File: rtl/fc_acc_relu.sv
// Accumulates N_IN signed products per neuron, then holds the ReLU/requantized result
// until the downstream stage takes it.
module fc_acc_relu
  import fc_pkg::*;
#(
  parameter int N_IN  = 16,
  parameter int SHIFT = 4,
  parameter int ACC_W = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [15:0]      in_prod,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [7:0]       out_data,
  output logic signed [ACC_W-1:0] out_acc,
  output logic                    out_sat
);

  localparam int                CNT_W    = $clog2(N_IN);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N_IN - 1);

  if (ACC_W < 16 + $clog2(N_IN)) begin : g_acc_w_check
    $error("fc_acc_relu: ACC_W too narrow for N_IN products");
  end

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [7:0]       out_data_q, out_data_d;
  logic signed [ACC_W-1:0] out_acc_q, out_acc_d;
  logic                    out_sat_q, out_sat_d;

  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [7:0]       relu_value;
  logic                    relu_sat;

  assign prod_ext = {{(ACC_W-16){in_prod[15]}}, in_prod};
  assign sum      = acc_q + prod_ext;

  relu_q8 #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_relu_q8 (
    .acc   (sum),
    .value (relu_value),
    .sat   (relu_sat)
  );

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_data  = out_data_q;
  assign out_acc   = out_acc_q;
  assign out_sat   = out_sat_q;

  // clr wins over a same-cycle product but only while accumulating.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_acc_d  = out_acc_q;
    out_sat_d  = out_sat_q;
    case (state_q)
      ACCUM: begin
        if (clr) begin
          acc_d = '0;
          cnt_d = '0;
        end else if (in_valid) begin
          if (cnt_q == CNT_LAST) begin
            out_acc_d  = sum;
            out_data_d = relu_value;
            out_sat_d  = relu_sat;
            acc_d      = '0;
            cnt_d      = '0;
            state_d    = HOLD;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_acc_q  <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_acc_q  <= out_acc_d;
      out_sat_q  <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_fc_acc_relu.sv
// Self-checking bench for fc_acc_relu: directed table, corner sequences and random
// neurons checked against an arithmetic reference model.
module tb_fc_acc_relu;

  localparam int N_IN  = 4;
  localparam int SHIFT = 2;
  localparam int ACC_W = 18;

  logic                    clk;
  logic                    rst;
  logic                    clr;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [15:0]      in_prod;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [7:0]       out_data;
  logic signed [ACC_W-1:0] out_acc;
  logic                    out_sat;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int     prod [N_IN];
    longint exp_acc;
    int     exp_data;
    bit     exp_sat;
  } vec_t;

  vec_t vecs [6];

  fc_acc_relu #(
    .N_IN  (N_IN),
    .SHIFT (SHIFT),
    .ACC_W (ACC_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_acc   (out_acc),
    .out_sat   (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mkVec(input int a, input int b, input int c, input int d,
                                 input longint acc, input int data, input bit sat);
    vec_t v;
    v.prod[0] = a; v.prod[1] = b; v.prod[2] = c; v.prod[3] = d;
    v.exp_acc = acc; v.exp_data = data; v.exp_sat = sat;
    return v;
  endfunction

  // Reference: plain sum, clamp at zero, divide by 2^SHIFT, saturate at 127.
  function automatic void refModel(input int prods [N_IN], output longint acc,
                                   output int data, output bit sat);
    longint r;
    acc = 0;
    for (int i = 0; i < N_IN; i++) acc += prods[i];
    r    = (acc < 0) ? 0 : acc / (longint'(1) << SHIFT);
    sat  = (r > 127);
    data = sat ? 127 : int'(r);
  endfunction

  task automatic applyStimulus(input int prods [N_IN], input string tag);
    for (int i = 0; i < N_IN; i++) begin
      check({tag, " in_ready"}, longint'(in_ready), 1);
      in_valid = 1'b1;
      in_prod  = 16'(prods[i]);
      @(posedge clk);
      #1;
      if (i < N_IN - 1) check({tag, " early out_valid"}, longint'(out_valid), 0);
    end
    in_valid = 1'b0;
    check({tag, " out_valid"}, longint'(out_valid), 1);
  endtask

  task automatic checkOutput(input string tag, input longint exp_acc, input int exp_data,
                             input bit exp_sat);
    check({tag, " out_acc"}, longint'(out_acc), exp_acc);
    check({tag, " out_data"}, longint'(out_data), longint'(exp_data));
    check({tag, " out_sat"}, longint'(out_sat), longint'(exp_sat));
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, " drain in_ready"}, longint'(in_ready), 1);
    check({tag, " drain out_valid"}, longint'(out_valid), 0);
  endtask

  task automatic feedPartial(input int value, input int count);
    for (int i = 0; i < count; i++) begin
      in_valid = 1'b1;
      in_prod  = 16'(value);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int     p [N_IN];
    longint m_acc;
    int     m_data;
    bit     m_sat;

    vecs[0] = mkVec(10, 20, 30, 40, 100, 25, 1'b0);
    vecs[1] = mkVec(-100, 20, 30, 10, -40, 0, 1'b0);
    vecs[2] = mkVec(32767, 32767, 32767, 32767, 131068, 127, 1'b1);
    vecs[3] = mkVec(-32768, -32768, -32768, -32768, -131072, 0, 1'b0);
    vecs[4] = mkVec(0, 0, 0, 511, 511, 127, 1'b0);
    vecs[5] = mkVec(0, 0, 0, 512, 512, 127, 1'b1);

    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_prod = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", longint'(in_ready), 1);
    check("reset out_valid", longint'(out_valid), 0);
    checkOutput("reset", 0, 0, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int v = 0; v < 6; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      applyStimulus(vecs[v].prod, tag);
      checkOutput(tag, vecs[v].exp_acc, vecs[v].exp_data, vecs[v].exp_sat);
      drain(tag);
    end

    // Backpressure: stalled result must stay put and offered products must not be taken.
    p = '{10, 20, 30, 40};
    applyStimulus(p, "bp");
    in_valid = 1'b1;
    in_prod  = 16'(999);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("bp hold out_valid", longint'(out_valid), 1);
      check("bp hold in_ready", longint'(in_ready), 0);
      checkOutput("bp hold", 100, 25, 1'b0);
    end
    in_valid = 1'b0;
    drain("bp");
    p = '{1, 1, 1, 1};
    applyStimulus(p, "bp next");
    checkOutput("bp next", 4, 1, 1'b0);
    drain("bp next");

    // Reset mid-neuron after a saturated result so every output has to change.
    p = '{32767, 32767, 32767, 32767};
    applyStimulus(p, "pre-rst");
    checkOutput("pre-rst", 131068, 127, 1'b1);
    drain("pre-rst");
    feedPartial(5, 2);
    rst = 1'b1;
    #1;
    check("midrst in_ready", longint'(in_ready), 1);
    check("midrst out_valid", longint'(out_valid), 0);
    checkOutput("midrst", 0, 0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    p = '{4, 4, 4, 4};
    applyStimulus(p, "post-rst");
    checkOutput("post-rst", 16, 4, 1'b0);

    // clr in HOLD is ignored.
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("clr in hold out_valid", longint'(out_valid), 1);
    checkOutput("clr in hold", 16, 4, 1'b0);
    drain("post-rst");

    // clr in ACCUM drops the partial sum and the same-cycle product.
    feedPartial(7, 2);
    in_valid = 1'b1;
    in_prod  = 16'(7);
    clr      = 1'b1;
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    check("clr out_valid", longint'(out_valid), 0);
    p = '{8, 8, 8, 8};
    applyStimulus(p, "post-clr");
    checkOutput("post-clr", 32, 8, 1'b0);
    drain("post-clr");

    for (int k = 0; k < 20; k++) begin
      string tag;
      int    stall;
      tag = $sformatf("rand%0d", k);
      for (int i = 0; i < N_IN; i++) begin
        if (k % 2 == 0) p[i] = int'($urandom_range(65535)) - 32768;
        else            p[i] = int'($urandom_range(1200)) - 200;
      end
      refModel(p, m_acc, m_data, m_sat);
      applyStimulus(p, tag);
      checkOutput(tag, m_acc, m_data, m_sat);
      stall = int'($urandom_range(3));
      for (int c = 0; c < stall; c++) begin
        @(posedge clk);
        #1;
        check({tag, " stall out_acc"}, longint'(out_acc), m_acc);
      end
      drain(tag);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc_acc_relu.md
FC_ACC_RELU -- requirements
Module: fc_acc_relu

Interface
REQ-001 SHALL have parameter N_IN, default 16, meaning number of products accumulated per neuron (2..256).
REQ-002 SHALL have parameter SHIFT, default 4, meaning arithmetic right shift applied before requantization (0..15).
REQ-003 SHALL have parameter ACC_W, default 24, meaning accumulator width; the block SHALL require ACC_W >= 16+clog2(N_IN).
REQ-004 SHALL have clk  input  1  meaning the single clock; all state is updated on the rising edge.
REQ-005 SHALL have rst  input  1  meaning reset, asynchronous and active-high.
REQ-006 SHALL have clr  input  1  meaning synchronous abort of the partial sum.
REQ-007 SHALL have in_valid  input  1  meaning in_prod is valid.
REQ-008 SHALL have in_ready  output  1  meaning the block accepts in_prod.
REQ-009 SHALL have in_prod  input  16 signed  meaning one node*weight+bias product from the upstream multiplier.
REQ-010 SHALL have out_valid  output  1  meaning the result is valid.
REQ-011 SHALL have out_ready  input  1  meaning the downstream stage accepts the result.
REQ-012 SHALL have out_data  output  8 signed  meaning the activated, requantized neuron value.
REQ-013 SHALL have out_acc  output  ACC_W signed  meaning the raw sum before activation.
REQ-014 SHALL have out_sat  output  1  meaning out_data was clipped at +127.

Function
REQ-015 SHALL have two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-016 SHALL, in ACCUM, on each in_valid&in_ready, sign-extend in_prod to ACC_W, add it to acc, and increment cnt.
REQ-017 SHALL, on the handshake with cnt==N_IN-1, register the following, clear acc and cnt to 0, and enter HOLD the next cycle: out_acc=acc+in_prod; r=max(out_acc,0)>>>SHIFT; out_data=min(r,127); out_sat=(r>127).
REQ-018 SHALL produce out_valid=1 exactly one cycle after the last product is accepted.
REQ-019 SHALL hold out_data, out_acc and out_sat stable in HOLD until out_valid&out_ready, then return to ACCUM the next cycle; there is no bypass, so the throughput is N_IN+1 cycles per neuron minimum.
REQ-020 SHALL, on a negative sum, give out_data=0 and out_sat=0 (ReLU).
REQ-021 SHALL never wrap acc for any legal N_IN; the ACC_W rule guarantees this.
REQ-022 SHALL, when clr=1 in ACCUM, zero acc and cnt, and ignore any same-cycle product (clr has priority).
REQ-023 SHALL ignore clr in HOLD, so the pending result is never lost.
REQ-024 SHALL not change in_ready combinationally with in_valid; in_ready SHALL depend on the state only.

Reset
REQ-025 SHALL, on rst=1, immediately drive state=ACCUM, acc=0, cnt=0, out_data=0, out_acc=0, out_sat=0, out_valid=0, in_ready=1.
REQ-026 SHALL discard any partial sum or pending result on reset mid-operation, and start the first product after rst deasserts at cnt=0.

Structure
REQ-027 SHALL place the state enum (ACCUM, HOLD) and the INT8_MAX=127 constant in the shared fc_pkg package.
REQ-028 SHALL place the ReLU/shift/saturate arithmetic in one combinational sub-module named relu_q8 (input ACC_W signed, outputs 8-bit value and sat flag).
REQ-029 SHALL keep cnt width clog2(N_IN).

Verification (N_IN=4, SHIFT=2, ACC_W=18)
REQ-030 SHALL cover: products 10,20,30,40 back-to-back -> out_acc=100, out_data=25, out_sat=0, out_valid one cycle after the 4th handshake.
REQ-031 SHALL cover: products -100,20,30,10 -> out_acc=-40, out_data=0, out_sat=0.
REQ-032 SHALL cover: 4×32767 -> out_acc=131068, out_data=127, out_sat=1; and 4×-32768 -> out_acc=-131072, out_data=0.
REQ-033 SHALL cover: out_ready=0 for 5 cycles in HOLD -> outputs stable, in_ready=0, products not consumed; out_ready=1 -> ACCUM next cycle, next neuron 1,1,1,1 -> out_data=1.
REQ-034 SHALL cover: rst pulse after 2 products -> all outputs 0 immediately; then 4,4,4,4 -> out_acc=16, out_data=4.
REQ-035 SHALL cover: clr together with in_valid after 2 of 7,7 -> product dropped; then 8,8,8,8 -> out_acc=32, out_data=8.
